// File: rtl/lc3_memaccess.sv
// LC3 memory-access stage: sequences LD/LDR, LDI, ST/STR and STI against a
// synchronous single-port data memory with one-cycle read latency.
module lc3_memaccess (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] M_Addr,
    input  logic [15:0] M_Data,
    input  logic [15:0] dmem_dout,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_din,
    output logic        dmem_rd,
    output logic        dmem_we,
    output logic [15:0] memout,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, IND_RD, IND_CAP, RD, RD_CAP, WR, DONE
    } state_t;

    state_t      state, state_nx;
    logic [1:0]  op_l;
    logic [15:0] addr_l;
    logic [15:0] data_l;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            op_l   <= 2'd0;
            addr_l <= 16'd0;
            data_l <= 16'd0;
            memout <= 16'd0;
        end else begin
            state <= state_nx;
            if (state == IDLE && start) begin
                op_l   <= op;
                addr_l <= M_Addr;
                data_l <= M_Data;
            end
            // Indirect ops replace the address with the fetched pointer.
            if (state == IND_CAP)
                addr_l <= dmem_dout;
            if (state == RD_CAP)
                memout <= dmem_dout;
        end
    end

    always_comb begin
        state_nx  = state;
        dmem_addr = 16'd0;
        dmem_din  = 16'd0;
        dmem_rd   = 1'b0;
        dmem_we   = 1'b0;
        done      = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) begin
                    if (op[0])      state_nx = IND_RD;
                    else if (op[1]) state_nx = WR;
                    else            state_nx = RD;
                end
            end
            IND_RD: begin
                dmem_addr = addr_l;
                dmem_rd   = 1'b1;
                state_nx  = IND_CAP;
            end
            IND_CAP: state_nx = op_l[1] ? WR : RD;
            RD: begin
                dmem_addr = addr_l;
                dmem_rd   = 1'b1;
                state_nx  = RD_CAP;
            end
            RD_CAP: state_nx = DONE;
            WR: begin
                dmem_addr = addr_l;
                dmem_din  = data_l;
                dmem_we   = 1'b1;
                state_nx  = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_lc3_memaccess.sv
// Bench for lc3_memaccess: directed vector table, hand-built corner cases and
// random transactions checked against a word-level memory/load model.
module tb_lc3_memaccess;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [1:0]  op;
    logic [15:0] M_Addr, M_Data, dmem_dout;
    logic [15:0] dmem_addr, dmem_din, memout;
    logic        dmem_rd, dmem_we, busy, done;

    lc3_memaccess dut (
        .clk(clk), .rst(rst), .start(start), .op(op),
        .M_Addr(M_Addr), .M_Data(M_Data), .dmem_dout(dmem_dout),
        .dmem_addr(dmem_addr), .dmem_din(dmem_din),
        .dmem_rd(dmem_rd), .dmem_we(dmem_we),
        .memout(memout), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous single-port memory; the preload port is used only while idle.
    logic [15:0] mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = 16'd0, pl_data = 16'd0;
    always @(posedge clk) begin
        if (pl_we)
            mem[pl_addr] <= pl_data;
        else begin
            if (dmem_we) mem[dmem_addr] <= dmem_din;
            if (dmem_rd) dmem_dout <= mem[dmem_addr];
        end
    end

    typedef struct {
        logic [1:0]  op;
        logic [15:0] addr, data;
        int          lat, nrd, nwr;
        logic [15:0] rd0, rd1, wa, wd, memout;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] ref_mem [int];
    logic [15:0] exp_memout;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 1'b0;
        ref_mem[int'(a)] = d;
    endtask

    // Issue one request, watch every cycle until done (or the budget runs out).
    // poke_c / rst_c inject a start(op=ST) pulse or a reset during that cycle.
    task automatic exec_vec(input string tag, input vec_t v, input int poke_c, input int rst_c);
        int lat = -1, nrd = 0, nwr = 0, first_c = -1, nbusy_lo = 0, nboth = 0;
        logic [15:0] rd0 = 16'd0, rd1 = 16'd0, wa = 16'd0, wd = 16'd0;
        start = 1'b1; op = v.op; M_Addr = v.addr; M_Data = v.data;
        @(posedge clk); #1;
        for (int c = 1; c <= 12; c++) begin
            if (dmem_rd && dmem_we) nboth++;
            if (dmem_rd) begin
                if (nrd == 0) rd0 = dmem_addr; else rd1 = dmem_addr;
                nrd++;
                if (first_c < 0) first_c = c;
            end
            if (dmem_we) begin
                wa = dmem_addr; wd = dmem_din; nwr++;
                if (first_c < 0) first_c = c;
            end
            if (done) begin lat = c; break; end
            if (!busy) nbusy_lo++;
            start  = (c == poke_c);
            op     = (c == poke_c) ? 2'd2 : 2'($urandom);
            M_Addr = 16'($urandom);
            M_Data = 16'($urandom);
            rst    = (c == rst_c);
            @(posedge clk); #1;
        end
        start = 1'b0; rst = 1'b0;
        chk({tag, " latency"}, lat, v.lat);
        chk({tag, " reads"}, nrd, v.nrd);
        chk({tag, " writes"}, nwr, v.nwr);
        chk({tag, " first_strobe_cycle"}, first_c, 1);
        chk({tag, " rd_we_overlap"}, nboth, 0);
        if (v.nrd > 0) chk({tag, " rd_addr0"}, rd0, v.rd0);
        if (v.nrd > 1) chk({tag, " rd_addr1"}, rd1, v.rd1);
        if (v.nwr > 0) begin
            chk({tag, " wr_addr"}, wa, v.wa);
            chk({tag, " wr_data"}, wd, v.wd);
        end
        if (v.lat > 0) chk({tag, " busy_gap"}, nbusy_lo, 0);
        chk({tag, " memout"}, memout, v.memout);
        @(posedge clk); #1;
        chk({tag, " idle_done"}, done, 1'b0);
        chk({tag, " idle_busy"}, busy, 1'b0);
    endtask

    vec_t tbl [6];

    initial begin
        rst = 1'b1; start = 1'b1; op = 2'd2; M_Addr = 16'h1234; M_Data = 16'h5678;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("reset busy", busy, 1'b0);
            chk("reset we", dmem_we, 1'b0);
            chk("reset memout", memout, 16'h0000);
        end
        rst = 1'b0; start = 1'b0;

        preload(16'h3010, 16'hBEEF);
        preload(16'h3020, 16'h4000);
        preload(16'h4000, 16'h1234);
        preload(16'h3040, 16'hFFFF);

        //         op    addr      data     lat nrd nwr rd0       rd1       wa        wd        memout
        tbl[0] = '{2'd0, 16'h3010, 16'h0000, 3, 1, 0, 16'h3010, 16'h0000, 16'h0000, 16'h0000, 16'hBEEF};
        tbl[1] = '{2'd1, 16'h3020, 16'h0000, 5, 2, 0, 16'h3020, 16'h4000, 16'h0000, 16'h0000, 16'h1234};
        tbl[2] = '{2'd2, 16'h3030, 16'h00FF, 2, 0, 1, 16'h0000, 16'h0000, 16'h3030, 16'h00FF, 16'h1234};
        tbl[3] = '{2'd3, 16'h3040, 16'hA5A5, 4, 1, 1, 16'h3040, 16'h0000, 16'hFFFF, 16'hA5A5, 16'h1234};
        tbl[4] = '{2'd0, 16'h3030, 16'h0000, 3, 1, 0, 16'h3030, 16'h0000, 16'h0000, 16'h0000, 16'h00FF};
        tbl[5] = '{2'd0, 16'hFFFF, 16'h0000, 3, 1, 0, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'hA5A5};
        for (int i = 0; i < 6; i++)
            exec_vec($sformatf("vec%0d", i), tbl[i], 0, 0);
        ref_mem[32'h3030] = 16'h00FF;
        ref_mem[32'hFFFF] = 16'hA5A5;

        // start(op=ST) during an LDI must be ignored entirely.
        exec_vec("busy_start", '{2'd1, 16'h3020, 16'h0000, 5, 2, 0, 16'h3020, 16'h4000,
                                 16'h0000, 16'h0000, 16'h1234}, 2, 0);
        // Reset in cycle 2 of an LDI: only the pointer read happens, memout clears.
        exec_vec("rst_mid_ldi", '{2'd1, 16'h3020, 16'h0000, -1, 1, 0, 16'h3020, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000}, 0, 2);
        exp_memout = 16'h0000;

        for (int i = 0; i < 40; i++) begin
            logic [1:0]  o;
            logic [15:0] a, p, d, tgt;
            vec_t        v;
            o = 2'($urandom_range(0, 3));
            a = (i % 8 == 0) ? 16'hFFFF : 16'($urandom);
            p = (i % 8 == 1) ? 16'hFFFF : 16'($urandom);
            d = 16'($urandom);
            preload(a, o[0] ? p : 16'($urandom));
            if (p != a) preload(p, 16'($urandom));
            tgt = o[0] ? ref_mem[int'(a)] : a;
            v.op = o; v.addr = a; v.data = d;
            v.lat = 2 + (o[0] ? 2 : 0) + (o[1] ? 0 : 1);
            v.nrd = (o[0] ? 1 : 0) + (o[1] ? 0 : 1);
            v.nwr = o[1] ? 1 : 0;
            v.rd0 = a; v.rd1 = tgt; v.wa = tgt; v.wd = d;
            if (o[1]) ref_mem[int'(tgt)] = d;
            else      exp_memout = ref_mem[int'(tgt)];
            v.memout = exp_memout;
            exec_vec($sformatf("rnd%0d_op%0d", i, o), v, 0, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
